// File: rtl/param_menu_pkg.sv
// Shared types and default tables for the parameter menu bank.
package param_menu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rep_state_t;

    // Index 0 sits in the least significant slice.
    localparam logic [79:0] DEF_PARAM_MAX = {
        16'd3, 16'd1, 16'd4095, 16'd65535, 16'd7
    };

    localparam logic [79:0] DEF_PARAM_DEFAULT = {
        16'd0, 16'd0, 16'd0, 16'd48000, 16'd0
    };

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/param_menu_bank_btn_repeat.sv
// Rising-edge detection for the next/prev pair plus hold-to-repeat stepping.
module btn_repeat
    import param_menu_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic arm_i,
    input  logic inc_i,
    input  logic dec_i,
    input  logic clr_i,
    output logic step_o,
    output logic dir_o
);

    localparam int MAXC = max_int(HOLD_CYCLES, REPEAT_CYCLES);
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    rep_state_t      state_q;
    logic [CW-1:0]   cnt_q;
    logic            inc_q, dec_q, dir_q;
    logic            inc_e, dec_e, held, other, keep;

    assign inc_e = inc_i & ~inc_q & arm_i;
    assign dec_e = dec_i & ~dec_q & arm_i;
    // dir_q = 1 means the repeat was started by the decrement button.
    assign held  = dir_q ? dec_i : inc_i;
    assign other = dir_q ? inc_i : dec_i;
    assign keep  = held & ~other & ~clr_i;

    always_comb begin
        step_o = 1'b0;
        dir_o  = dir_q;
        unique case (state_q)
            IDLE: begin
                if (inc_e) begin
                    step_o = 1'b1;
                    dir_o  = 1'b0;
                end else if (dec_e) begin
                    step_o = 1'b1;
                    dir_o  = 1'b1;
                end
            end
            HOLD:    step_o = keep && (cnt_q == HOLD_LAST);
            REPEAT:  step_o = keep && (cnt_q == REP_LAST);
            default: step_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            inc_q <= inc_i;
            dec_q <= dec_i;
            if (state_q == IDLE) begin
                cnt_q <= '0;
                if (inc_e || dec_e) begin
                    state_q <= HOLD;
                    dir_q   <= ~inc_e;
                end
            end else if (!keep) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else if (cnt_q == ((state_q == HOLD) ? HOLD_LAST : REP_LAST)) begin
                state_q <= REPEAT;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/param_menu_bank.sv
// Paged bank of bounded parameters edited by buttons and switches.
module param_menu_bank
    import param_menu_pkg::*;
#(
    parameter int NUM_PARAMS    = 5,
    parameter int VAL_W         = 16,
    parameter logic [NUM_PARAMS*VAL_W-1:0] PARAM_MAX     = DEF_PARAM_MAX,
    parameter logic [NUM_PARAMS*VAL_W-1:0] PARAM_DEFAULT = DEF_PARAM_DEFAULT,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic                          clk_100mhz,
    input  logic                          rst,
    input  logic                          up,
    input  logic                          down,
    input  logic                          next,
    input  logic                          prev,
    input  logic                          set,
    input  logic [15:0]                   sw,
    output logic [NUM_PARAMS*VAL_W-1:0]   vals,
    output logic [$clog2(NUM_PARAMS)-1:0] page,
    output logic                          upd_valid,
    output logic [$clog2(NUM_PARAMS)-1:0] upd_idx
);

    localparam int PW = $clog2(NUM_PARAMS);

    logic [VAL_W-1:0] vals_q [NUM_PARAMS];
    logic [PW-1:0]    page_q, page_d, upd_idx_q;
    logic             up_q, down_q, set_q, armed_q, upd_valid_q;
    logic             up_e, down_e, set_e, pg_chg, step, dir, chg;
    logic [VAL_W-1:0] cur, pmax, sw_v, new_v;

    // armed_q masks edges in the first cycle after reset release.
    assign up_e   = up & ~up_q & armed_q;
    assign down_e = down & ~down_q & armed_q;
    assign set_e  = set & ~set_q & armed_q;
    assign pg_chg = up_e ^ down_e;

    btn_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_rep (
        .clk_i (clk_100mhz),
        .rst_i (rst),
        .arm_i (armed_q),
        .inc_i (next),
        .dec_i (prev),
        .clr_i (pg_chg),
        .step_o(step),
        .dir_o (dir)
    );

    always_comb begin
        page_d = page_q;
        if (up_e && !down_e) begin
            page_d = (page_q == PW'(NUM_PARAMS - 1)) ? '0 : page_q + PW'(1);
        end else if (down_e && !up_e) begin
            page_d = (page_q == '0) ? PW'(NUM_PARAMS - 1) : page_q - PW'(1);
        end
    end

    always_comb begin
        cur   = vals_q[page_q];
        pmax  = PARAM_MAX[page_q*VAL_W +: VAL_W];
        sw_v  = VAL_W'(sw);
        new_v = cur;
        if (set_e) begin
            new_v = (sw_v > pmax) ? pmax : sw_v;
        end else if (step && !dir) begin
            new_v = (cur == pmax) ? '0 : cur + VAL_W'(1);
        end else if (step) begin
            new_v = (cur == '0) ? pmax : cur - VAL_W'(1);
        end
        chg = (new_v != cur);
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                vals_q[i] <= PARAM_DEFAULT[i*VAL_W +: VAL_W];
            end
            page_q      <= '0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            set_q       <= 1'b0;
            armed_q     <= 1'b0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
        end else begin
            armed_q        <= 1'b1;
            up_q           <= up;
            down_q         <= down;
            set_q          <= set;
            page_q         <= page_d;
            vals_q[page_q] <= new_v;
            upd_valid_q    <= chg;
            if (chg) begin
                upd_idx_q <= page_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_out
        assign vals[g*VAL_W +: VAL_W] = vals_q[g];
    end

    assign page      = page_q;
    assign upd_valid = upd_valid_q;
    assign upd_idx   = upd_idx_q;

endmodule

// File: tb/tb_param_menu_bank.sv
// Self-checking bench for param_menu_bank: vector table plus hold/reset sequences.
module tb_param_menu_bank;
    import param_menu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up = 1'b0, down = 1'b0, next = 1'b0, prev = 1'b0, set = 1'b0;
    logic [15:0] sw = '0;
    logic [79:0] vals;
    logic [2:0]  page, upd_idx;
    logic        upd_valid;

    localparam logic [79:0] EXP_DEF = {16'd0, 16'd0, 16'd0, 16'd48000, 16'd0};

    always #5 clk = ~clk;

    param_menu_bank #(
        .HOLD_CYCLES  (10),
        .REPEAT_CYCLES(4)
    ) dut (
        .clk_100mhz(clk),
        .rst       (rst),
        .up        (up),
        .down      (down),
        .next      (next),
        .prev      (prev),
        .set       (set),
        .sw        (sw),
        .vals      (vals),
        .page      (page),
        .upd_valid (upd_valid),
        .upd_idx   (upd_idx)
    );

    typedef struct {
        int idx;
        int val;
    } exp_t;

    typedef struct {
        logic        u, d, n, p, s;
        logic [15:0] w;
        int          pg, ix, vl;
        bit          upd;
    } vec_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic int vo(input int i);
        return int'(vals[i*16 +: 16]);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input int v);
        exp_t e;
        e.idx = i;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk_defaults(input string nm);
        for (int i = 0; i < 5; i++) begin
            chk(nm, vo(i), int'(EXP_DEF[i*16 +: 16]));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (upd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL upd_unexpected: got idx %0d val %0d, expected no update",
                         upd_idx, vo(int'(upd_idx)));
            end else begin
                e = sb.pop_front();
                chk("upd_idx", int'(upd_idx), e.idx);
                chk("upd_val", vo(int'(upd_idx)), e.val);
            end
        end
    end

    function automatic vec_t mk(input logic u, input logic d, input logic n,
                                input logic p, input logic s, input logic [15:0] w,
                                input int pg, input int ix, input int vl, input bit ud);
        vec_t v;
        v.u = u; v.d = d; v.n = n; v.p = p; v.s = s; v.w = w;
        v.pg = pg; v.ix = ix; v.vl = vl; v.upd = ud;
        return v;
    endfunction

    function automatic int hold_steps(input int k);
        return (k >= 10) ? 2 + (k - 10) / 4 : 1;
    endfunction

    vec_t tv[28];

    initial begin
        tv[0]  = mk(1, 0, 0, 0, 0, 16'h0,    1, 1, 48000, 0);
        tv[1]  = mk(1, 0, 0, 0, 0, 16'h0,    2, 2, 0,     0);
        tv[2]  = mk(1, 0, 0, 0, 0, 16'h0,    3, 3, 0,     0);
        tv[3]  = mk(1, 0, 0, 0, 0, 16'h0,    4, 4, 0,     0);
        tv[4]  = mk(1, 0, 0, 0, 0, 16'h0,    0, 0, 0,     0);
        tv[5]  = mk(0, 1, 0, 0, 0, 16'h0,    4, 4, 0,     0);
        tv[6]  = mk(1, 0, 0, 0, 0, 16'h0,    0, 0, 0,     0);
        tv[7]  = mk(0, 0, 0, 1, 0, 16'h0,    0, 0, 7,     1);
        tv[8]  = mk(0, 0, 1, 0, 0, 16'h0,    0, 0, 0,     1);
        tv[9]  = mk(1, 0, 0, 0, 0, 16'h0,    1, 1, 48000, 0);
        tv[10] = mk(1, 0, 0, 0, 0, 16'h0,    2, 2, 0,     0);
        tv[11] = mk(0, 0, 0, 0, 1, 16'haeae, 2, 2, 4095,  1);
        tv[12] = mk(0, 0, 0, 0, 1, 16'haeae, 2, 2, 4095,  0);
        tv[13] = mk(0, 0, 1, 0, 0, 16'h0,    2, 2, 0,     1);
        tv[14] = mk(0, 0, 0, 1, 0, 16'h0,    2, 2, 4095,  1);
        tv[15] = mk(1, 0, 0, 0, 0, 16'h0,    3, 3, 0,     0);
        tv[16] = mk(0, 0, 1, 0, 1, 16'h1,    3, 3, 1,     1);
        tv[17] = mk(1, 1, 0, 0, 0, 16'h0,    3, 3, 1,     0);
        tv[18] = mk(0, 0, 1, 0, 0, 16'h0,    3, 3, 0,     1);
        tv[19] = mk(1, 0, 1, 0, 0, 16'h0,    4, 3, 1,     1);
        tv[20] = mk(0, 0, 0, 0, 1, 16'h2,    4, 4, 2,     1);
        tv[21] = mk(0, 1, 0, 0, 0, 16'h0,    3, 3, 1,     0);
        tv[22] = mk(0, 0, 0, 0, 1, 16'h0,    3, 3, 0,     1);
        tv[23] = mk(0, 1, 0, 0, 0, 16'h0,    2, 2, 4095,  0);
        tv[24] = mk(0, 1, 0, 0, 0, 16'h0,    1, 1, 48000, 0);
        tv[25] = mk(0, 1, 0, 0, 0, 16'h0,    0, 0, 0,     0);
        tv[26] = mk(0, 0, 1, 1, 0, 16'h0,    0, 0, 1,     1);
        tv[27] = mk(0, 0, 0, 0, 1, 16'h0,    0, 0, 0,     1);

        // Reset state
        cyc();
        cyc();
        chk("rst_page", int'(page), 0);
        chk("rst_upd_valid", int'(upd_valid), 0);
        chk("rst_upd_idx", int'(upd_idx), 0);
        chk_defaults("rst_vals");
        rst = 1'b0;
        cyc();

        // Single-cycle button vectors
        foreach (tv[i]) begin
            up = tv[i].u; down = tv[i].d; next = tv[i].n;
            prev = tv[i].p; set = tv[i].s; sw = tv[i].w;
            if (tv[i].upd) push(tv[i].ix, tv[i].vl);
            cyc();
            chk($sformatf("vec%0d_page", i), int'(page), tv[i].pg);
            chk($sformatf("vec%0d_val", i), vo(tv[i].ix), tv[i].vl);
            up = 0; down = 0; next = 0; prev = 0; set = 0;
            cyc();
        end

        // Hold next on page 0 for 30 cycles
        for (int k = 1; k <= 6; k++) push(0, k);
        next = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cyc();
            chk($sformatf("hold_k%0d", k), vo(0), hold_steps(k));
        end
        next = 1'b0;
        cyc();
        chk("hold_fsm_idle", int'(dut.u_rep.state_q), int'(IDLE));
        repeat (15) cyc();
        chk("hold_after_release", vo(0), 6);

        // prev held, then next also pressed: repeat must stop
        prev = 1'b1;
        push(0, 5);
        cyc();
        cyc();
        cyc();
        next = 1'b1;
        repeat (15) cyc();
        chk("conflict_val", vo(0), 5);
        next = 1'b0;
        prev = 1'b0;
        cyc();

        // Page change while holding next
        next = 1'b1;
        push(0, 6);
        cyc();
        repeat (3) cyc();
        up = 1'b1;
        cyc();
        up = 1'b0;
        repeat (20) cyc();
        chk("pgchg_v0", vo(0), 6);
        chk("pgchg_v1", vo(1), 48000);
        chk("pgchg_page", int'(page), 1);
        next = 1'b0;
        cyc();
        down = 1'b1;
        cyc();
        down = 1'b0;
        cyc();
        chk("pgchg_back", int'(page), 0);

        // Reset in the middle of a repeat on page 4
        down = 1'b1;
        cyc();
        down = 1'b0;
        cyc();
        chk("mid_page4", int'(page), 4);
        push(4, 3);
        push(4, 0);
        push(4, 1);
        next = 1'b1;
        repeat (16) cyc();
        chk("mid_v4", vo(4), 1);
        rst = 1'b1;
        #2;
        chk_defaults("mid_rst_vals");
        chk("mid_rst_page", int'(page), 0);
        chk("mid_rst_upd", int'(upd_valid), 0);
        cyc();
        rst = 1'b0;
        repeat (20) cyc();
        chk_defaults("post_rst_vals");
        chk("post_rst_page", int'(page), 0);
        next = 1'b0;
        cyc();
        next = 1'b1;
        push(0, 1);
        cyc();
        chk("repress_v0", vo(0), 1);
        next = 1'b0;
        cyc();
        cyc();

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
